// File: rtl/equalize_sequencer.sv
// Frame sequencer for histogram equalization: launches the histogram, CDF and
// output stages in turn, captures the CDF minimum and computes the output divisor.
// Optional feature: define SEQ_TIMEOUT_EN to abort any stage that runs for
// TIMEOUT_CYCLES cycles. When it is undefined, stages wait indefinitely and error stays 0.
module equalize_sequencer #(
    parameter int unsigned NUM_PIXELS     = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        hist_start,
    output logic        cdf_start,
    output logic        out_start,
    input  logic        hist_done,
    input  logic        cdf_done,
    input  logic        out_done,
    input  logic [19:0] cdf_min_in,
    input  logic        cdf_min_valid,
    output logic [19:0] CdfMin,
    output logic [19:0] divisor,
    output logic        output_base_offset,
    output logic [15:0] frame_count,
    output logic        error
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HIST   = 3'd1;
    localparam logic [2:0] CDF    = 3'd2;
    localparam logic [2:0] CALC   = 3'd3;
    localparam logic [2:0] OUT    = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    localparam logic [19:0] NumPix = 20'(NUM_PIXELS);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic       cdfMinSeen;
    logic       timeoutHit;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] stageCnt;
    logic        stageStuck;

    // A stage is stuck when its done input is still low in its last allowed cycle.
    always_comb begin
        stageStuck = 1'b0;
        case (state)
            HIST:    stageStuck = !hist_done;
            CDF:     stageStuck = !cdf_done;
            OUT:     stageStuck = !out_done;
            default: stageStuck = 1'b0;
        endcase
        timeoutHit = stageStuck && (stageCnt == TimeoutLast);
    end

    // Per-stage cycle counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            stageCnt <= '0;
            error    <= 1'b0;
        end else begin
            stageCnt <= (stateNext != state) ? '0 : stageCnt + 32'd1;
            if (state == IDLE && start) begin
                error <= 1'b0;
            end else if (timeoutHit) begin
                error <= 1'b1;
            end
        end
    end
`else
    logic unusedTimeout;

    assign unusedTimeout = ^TIMEOUT_CYCLES;
    assign timeoutHit    = 1'b0;
    assign error         = 1'b0;
`endif

    // Next-state logic; each done input only matters in its own stage.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = HIST;
            HIST:    if (hist_done) stateNext = CDF;
            CDF:     if (cdf_done) stateNext = CALC;
            CALC:    stateNext = OUT;
            OUT:     if (out_done) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (timeoutHit) begin
            stateNext = IDLE;
        end
    end

    // State, launch pulses, operand capture and frame bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            hist_start         <= 1'b0;
            cdf_start          <= 1'b0;
            out_start          <= 1'b0;
            done               <= 1'b0;
            CdfMin             <= '0;
            cdfMinSeen         <= 1'b0;
            divisor            <= NumPix;
            output_base_offset <= 1'b0;
            frame_count        <= '0;
        end else begin
            state      <= stateNext;
            // Launch pulses are registered so they land in the first cycle of the stage.
            hist_start <= (stateNext == HIST) && (state != HIST);
            cdf_start  <= (stateNext == CDF) && (state != CDF);
            out_start  <= (stateNext == OUT) && (state != OUT);
            // done is registered off FINISH so it coincides with the updated counters.
            done       <= (state == FINISH);

            if (state == IDLE && start) begin
                CdfMin     <= '0;
                cdfMinSeen <= 1'b0;
            end else if (state == CDF && cdf_min_valid && !cdfMinSeen) begin
                CdfMin     <= cdf_min_in;
                cdfMinSeen <= 1'b1;
            end

            if (state == CALC) begin
                divisor <= (CdfMin >= NumPix) ? 20'd1 : NumPix - CdfMin;
            end

            if (state == FINISH) begin
                output_base_offset <= ~output_base_offset;
                frame_count        <= frame_count + 16'd1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/equalize_sequencer.md
EQUALIZE_SEQUENCER -- requirements
Module: equalize_sequencer

Interface
REQ-001 Parameter NUM_PIXELS, default 4096, number of pixels per frame (divisor numerator), 20-bit range.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, maximum cycles any stage may run before abort (used only when SEQ_TIMEOUT_EN is defined).
REQ-003 Port clock, input, 1, single clock; all logic rising-edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, frame request; sampled only in IDLE.
REQ-006 Port busy, output, 1, high in every state except IDLE.
REQ-007 Port done, output, 1, one-cycle frame-complete pulse.
REQ-008 Ports hist_start/cdf_start/out_start, output, 1 each, one-cycle stage launch pulses.
REQ-009 Ports hist_done/cdf_done/out_done, input, 1 each, stage completion levels or pulses.
REQ-010 Port cdf_min_in, input, 20, minimum non-zero CDF value from CDF stage; cdf_min_valid, input, 1, qualifies it.
REQ-011 Ports CdfMin and divisor, output, 20 each, registered operands to output pipeline.
REQ-012 Port output_base_offset, output, 1, output-memory bank select (ping-pong).
REQ-013 Port frame_count, output, 16, completed-frame counter; error, output, 1, stage-timeout flag.

Function
REQ-014 States: IDLE, HIST, CDF, CALC, OUT, FINISH.
REQ-015 IDLE->HIST on start=1; hist_start pulses in first HIST cycle only.
REQ-016 HIST->CDF on hist_done=1; cdf_start pulses in first CDF cycle only.
REQ-017 In CDF, first cycle with cdf_min_valid=1 captures cdf_min_in into CdfMin; later valids in same frame ignored.
REQ-018 CDF->CALC on cdf_done=1; if no valid seen, CdfMin=0.
REQ-019 CALC lasts exactly one cycle: divisor = NUM_PIXELS - CdfMin; if CdfMin >= NUM_PIXELS, divisor = 1.
REQ-020 CALC->OUT unconditionally; out_start pulses in first OUT cycle; CdfMin/divisor stable throughout OUT.
REQ-021 OUT->FINISH on out_done=1; FINISH lasts one cycle with done=1, then IDLE.
REQ-022 In FINISH: output_base_offset toggles, frame_count increments (wraps 0xFFFF->0).
REQ-023 Done inputs ignored outside their own state; start ignored while busy.
REQ-024 A done input high in the same cycle its stage start pulses is accepted (zero-length stage).
REQ-025 Minimum frame latency: start at cycle n -> done at cycle n+6 with all done inputs tied high.

Reset
REQ-026 Reset returns to IDLE next edge regardless of state, including mid-frame.
REQ-027 Reset values: busy=0, done=0, all *_start=0, CdfMin=0, divisor=NUM_PIXELS, output_base_offset=0, frame_count=0, error=0.
REQ-028 Reset has priority over start and all done inputs in the same cycle.

Configuration
REQ-029 Macro SEQ_TIMEOUT_EN defined: per-stage cycle counter clears on each stage entry; in HIST, CDF or OUT, reaching TIMEOUT_CYCLES without the stage done -> IDLE, error=1, no done pulse, frame_count and output_base_offset unchanged.
REQ-030 With SEQ_TIMEOUT_EN: error is sticky and clears on the next accepted start or reset.
REQ-031 Macro undefined: no counter synthesized, error tied 0, stages wait indefinitely.

Verification
REQ-032 All done inputs tied 1, start pulse at cycle 10 -> hist/cdf/out_start at 11/12/14, done at 16, frame_count=1, output_base_offset=1.
REQ-033 cdf_min_valid with cdf_min_in=1 then 7 in CDF, NUM_PIXELS=64 -> CdfMin=1, divisor=63.
REQ-034 cdf_min_in=5000, NUM_PIXELS=4096 -> divisor=1.
REQ-035 Reset asserted during OUT -> next cycle IDLE, busy=0, outputs at reset values, no done pulse.
REQ-036 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, hist_done held 0 -> IDLE with error=1 after 20 HIST cycles; next start clears error.
REQ-037 start re-pulsed during CDF and two back-to-back frames -> mid-frame start ignored; output_base_offset reads 1 then 0, frame_count=2.
